// File: rtl/cva5_types.sv
// Shared types and defaults for the LSQ issue arbiter.
package cva5_types;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 8;
    localparam int unsigned STARVE_CNT_W         = 8;

    typedef enum logic [1:0] {
        ARB        = 2'd0,
        LOCK_LOAD  = 2'd1,
        LOCK_STORE = 2'd2,
        DRAIN      = 2'd3
    } lsq_arb_state_t;

    // Subunit index width, never narrower than one bit.
    function automatic int unsigned subunit_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lsq_issue_arbiter_if.sv
// Request/grant bundle between the load/store queue heads and the issue arbiter.
interface lsq_issue_arbiter_if
    import cva5_types::*;
#(
    parameter int unsigned NUM_SUBUNITS = 4
);
    localparam int unsigned SUBUNIT_W = subunit_w(NUM_SUBUNITS);

    logic                    load_valid;
    logic [SUBUNIT_W-1:0]    load_subunit;
    logic                    load_multi;
    logic                    store_valid;
    logic [SUBUNIT_W-1:0]    store_subunit;
    logic                    store_multi;
    logic [NUM_SUBUNITS-1:0] subunit_ready;
    logic                    drain_req;
    logic                    sq_empty;
    logic                    load_pop;
    logic                    store_pop;
    logic                    issue_valid;
    logic                    issue_store;
    logic [SUBUNIT_W-1:0]    issue_subunit;
    logic                    drain_ack;

    modport master (
        output load_valid, load_subunit, load_multi,
        output store_valid, store_subunit, store_multi,
        output subunit_ready, drain_req, sq_empty,
        input  load_pop, store_pop, issue_valid, issue_store, issue_subunit, drain_ack
    );

    modport slave (
        input  load_valid, load_subunit, load_multi,
        input  store_valid, store_subunit, store_multi,
        input  subunit_ready, drain_req, sq_empty,
        output load_pop, store_pop, issue_valid, issue_store, issue_subunit, drain_ack
    );

endinterface

// File: rtl/lsq_issue_arbiter_starve.sv
// Saturating count of load grants that bypassed a waiting store.
module lsq_starve_counter
    import cva5_types::*;
#(
    parameter int unsigned LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    input  logic i_hold,
    output logic o_force_c
);
    localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] r_cnt;

    // Hold wins over clear so a lock freezes the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_hold) begin
            r_cnt <= r_cnt;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT_V)) begin
            r_cnt <= r_cnt + STARVE_CNT_W'(1);
        end
    end

    assign o_force_c = (r_cnt == LIMIT_V);

endmodule

// File: rtl/lsq_issue_arbiter.sv
// Same-cycle load/store issue arbiter with store anti-starvation, two-beat locks and fence drain.
module lsq_issue_arbiter
    import cva5_types::*;
#(
    parameter int unsigned NUM_SUBUNITS = 4,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    lsq_issue_arbiter_if.slave        bus
);
    localparam int unsigned SUBUNIT_W = subunit_w(NUM_SUBUNITS);

    lsq_arb_state_t r_state;
    lsq_arb_state_t w_next;

    logic w_load_ok;
    logic w_store_ok;
    logic w_force;
    logic w_load_pop;
    logic w_store_pop;
    logic w_drain_ack;
    logic w_locked;
    logic [SUBUNIT_W-1:0] w_subunit;

    assign w_load_ok  = bus.load_valid  & bus.subunit_ready[bus.load_subunit];
    assign w_store_ok = bus.store_valid & bus.subunit_ready[bus.store_subunit];
    assign w_locked   = (r_state == LOCK_LOAD) | (r_state == LOCK_STORE);

    lsq_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (w_load_pop & bus.store_valid),
        .i_clr     (w_store_pop | ~bus.store_valid),
        .i_hold    (w_locked),
        .o_force_c (w_force)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant selection and next state; a fence seen mid-lock takes effect when the lock ends.
    always_comb begin
        w_next      = r_state;
        w_load_pop  = 1'b0;
        w_store_pop = 1'b0;
        w_drain_ack = 1'b0;
        case (r_state)
            ARB: begin
                if (bus.drain_req) begin
                    w_store_pop = w_store_ok;
                    w_next      = (w_store_ok & bus.store_multi) ? LOCK_STORE : DRAIN;
                end else if (w_force & w_store_ok) begin
                    w_store_pop = 1'b1;
                    if (bus.store_multi) w_next = LOCK_STORE;
                end else if (w_load_ok) begin
                    w_load_pop = 1'b1;
                    if (bus.load_multi) w_next = LOCK_LOAD;
                end else if (w_store_ok) begin
                    w_store_pop = 1'b1;
                    if (bus.store_multi) w_next = LOCK_STORE;
                end
            end
            LOCK_LOAD: begin
                if (w_load_ok) begin
                    w_load_pop = 1'b1;
                    if (!bus.load_multi) w_next = bus.drain_req ? DRAIN : ARB;
                end
            end
            LOCK_STORE: begin
                if (w_store_ok) begin
                    w_store_pop = 1'b1;
                    if (!bus.store_multi) w_next = bus.drain_req ? DRAIN : ARB;
                end
            end
            DRAIN: begin
                w_store_pop = w_store_ok;
                w_drain_ack = bus.sq_empty & ~bus.store_valid;
                if (!bus.drain_req) w_next = ARB;
            end
            default: w_next = ARB;
        endcase
    end

    always_comb begin
        w_subunit = '0;
        if (w_store_pop) begin
            w_subunit = bus.store_subunit;
        end else if (w_load_pop) begin
            w_subunit = bus.load_subunit;
        end
    end

    // Outputs forced low for as long as reset is held.
    assign bus.load_pop      = rst & w_load_pop;
    assign bus.store_pop     = rst & w_store_pop;
    assign bus.issue_valid   = rst & (w_load_pop | w_store_pop);
    assign bus.issue_store   = rst & w_store_pop;
    assign bus.issue_subunit = rst ? w_subunit : '0;
    assign bus.drain_ack     = rst & w_drain_ack;

endmodule

// File: tb/tb_lsq_issue_arbiter.sv
// Directed, table-driven bench for lsq_issue_arbiter.
module tb_lsq_issue_arbiter;
    import cva5_types::*;

    localparam int unsigned NS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    lsq_issue_arbiter_if #(.NUM_SUBUNITS(NS)) bus ();

    lsq_issue_arbiter #(
        .NUM_SUBUNITS(NS),
        .STARVE_LIMIT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic       lv;
        logic [1:0] lsub;
        logic       lm;
        logic       sv;
        logic [1:0] ssub;
        logic       sm;
        logic [3:0] rdy;
        logic       drain;
        logic       sqe;
        logic [6:0] exp;   // {load_pop, store_pop, issue_valid, issue_store, issue_subunit, drain_ack}
    } vec_t;

    function automatic vec_t mk(string n, logic lv, logic [1:0] lsub, logic lm,
                                logic sv, logic [1:0] ssub, logic sm, logic [3:0] rdy,
                                logic drain, logic sqe,
                                logic lp, logic sp, logic [1:0] isub, logic ack);
        vec_t v;
        v.name = n; v.lv = lv; v.lsub = lsub; v.lm = lm;
        v.sv = sv; v.ssub = ssub; v.sm = sm; v.rdy = rdy;
        v.drain = drain; v.sqe = sqe;
        v.exp = {lp, sp, lp | sp, sp, isub, ack};
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {bus.load_pop, bus.store_pop, bus.issue_valid, bus.issue_store,
                bus.issue_subunit, bus.drain_ack};
    endfunction

    task automatic drive(input vec_t v);
        bus.load_valid    = v.lv;
        bus.load_subunit  = v.lsub;
        bus.load_multi    = v.lm;
        bus.store_valid   = v.sv;
        bus.store_subunit = v.ssub;
        bus.store_multi   = v.sm;
        bus.subunit_ready = v.rdy;
        bus.drain_req     = v.drain;
        bus.sq_empty      = v.sqe;
    endtask

    task automatic check(input string n, input logic [6:0] got, input logic [6:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %b expected %b (lp sp iv is sub[1:0] ack)", n, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Apply a vector mid-cycle, check the combinational grant, let the next edge consume it.
    task automatic cyc(input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check(v.name, outs(), v.exp);
    endtask

    vec_t tbl [21];
    vec_t v;
    logic [6:0] o;

    initial begin
        //           name          lv lsub  lm sv ssub  sm rdy      dr sqe  lp sp isub  ack
        tbl[0]  = mk("idle",       0, 2'd0, 0, 0, 2'd0, 0, 4'b1111, 0, 1,   0, 0, 2'd0, 0);
        tbl[1]  = mk("load_only",  1, 2'd2, 0, 0, 2'd0, 0, 4'b1111, 0, 0,   1, 0, 2'd2, 0);
        tbl[2]  = mk("store_only", 0, 2'd0, 0, 1, 2'd3, 0, 4'b1111, 0, 0,   0, 1, 2'd3, 0);
        tbl[3]  = mk("load_busy",  1, 2'd1, 0, 1, 2'd2, 0, 4'b1101, 0, 0,   0, 1, 2'd2, 0);
        tbl[4]  = mk("load_prio",  1, 2'd0, 0, 1, 2'd1, 0, 4'b1111, 0, 0,   1, 0, 2'd0, 0);
        tbl[5]  = mk("store_busy", 0, 2'd0, 0, 1, 2'd3, 0, 4'b0111, 0, 0,   0, 0, 2'd0, 0);
        tbl[6]  = mk("st_beat0",   1, 2'd0, 0, 1, 2'd2, 1, 4'b1110, 0, 0,   0, 1, 2'd2, 0);
        tbl[7]  = mk("st_lock_ld", 1, 2'd0, 0, 0, 2'd2, 0, 4'b1111, 0, 0,   0, 0, 2'd0, 0);
        tbl[8]  = mk("st_beat1",   1, 2'd0, 0, 1, 2'd2, 0, 4'b1111, 0, 0,   0, 1, 2'd2, 0);
        tbl[9]  = mk("fence_arb",  1, 2'd0, 0, 1, 2'd1, 0, 4'b1101, 1, 0,   0, 0, 2'd0, 0);
        tbl[10] = mk("drain_st1",  1, 2'd0, 0, 1, 2'd1, 0, 4'b1111, 1, 0,   0, 1, 2'd1, 0);
        tbl[11] = mk("drain_st2",  1, 2'd0, 0, 1, 2'd3, 0, 4'b1111, 1, 0,   0, 1, 2'd3, 0);
        tbl[12] = mk("drain_st3",  1, 2'd0, 0, 1, 2'd0, 0, 4'b1111, 1, 0,   0, 1, 2'd0, 0);
        tbl[13] = mk("drain_wait", 1, 2'd0, 0, 0, 2'd0, 0, 4'b1111, 1, 0,   0, 0, 2'd0, 0);
        tbl[14] = mk("drain_ack",  1, 2'd0, 0, 0, 2'd0, 0, 4'b1111, 1, 1,   0, 0, 2'd0, 1);
        tbl[15] = mk("drain_exit", 1, 2'd2, 0, 0, 2'd0, 0, 4'b1111, 0, 1,   0, 0, 2'd0, 1);
        tbl[16] = mk("post_drain", 1, 2'd2, 0, 0, 2'd0, 0, 4'b1111, 0, 1,   1, 0, 2'd2, 0);
        tbl[17] = mk("ld_beat0",   1, 2'd3, 1, 0, 2'd0, 0, 4'b1111, 0, 0,   1, 0, 2'd3, 0);
        tbl[18] = mk("ld_lock_st", 1, 2'd3, 0, 1, 2'd0, 0, 4'b0111, 0, 0,   0, 0, 2'd0, 0);
        tbl[19] = mk("ld_beat1",   1, 2'd3, 0, 1, 2'd0, 0, 4'b1111, 0, 0,   1, 0, 2'd3, 0);
        tbl[20] = mk("post_lock",  0, 2'd0, 0, 1, 2'd0, 0, 4'b1111, 0, 0,   0, 1, 2'd0, 0);

        // Reset held with every request active: all outputs must stay low.
        drive(mk("rst", 1, 2'd1, 1, 1, 2'd2, 1, 4'b1111, 1, 1, 0, 0, 2'd0, 0));
        #2;
        check("reset_hold", outs(), 7'd0);
        repeat (2) @(negedge clk);
        drive(mk("rst", 0, 2'd0, 0, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 0));
        rst = 1'b1;

        for (int i = 0; i < 21; i++) cyc(tbl[i]);

        // Starvation: 8 loads then one forced store, repeating.
        @(negedge clk);
        rst = 1'b0;
        drive(mk("rst", 1, 2'd1, 0, 1, 2'd2, 0, 4'b1111, 0, 0, 0, 0, 2'd0, 0));
        #1;
        check("reset_active", outs(), 7'd0);
        @(negedge clk);
        drive(mk("rst", 0, 2'd0, 0, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 0));
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(mk("starve", 1, 2'd1, 0, 1, 2'd2, 0, 4'b1111, 0, 0,
                   (i % 9) != 8, (i % 9) == 8, ((i % 9) == 8) ? 2'd2 : 2'd1, 0));
        end

        // Reset during LOCK_LOAD with the starve count near its limit.
        cyc(mk("clr_cnt", 0, 2'd1, 0, 1, 2'd2, 0, 4'b1111, 0, 0, 0, 1, 2'd2, 0));
        for (int i = 0; i < 7; i++) begin
            cyc(mk("pre_lock", 1, 2'd1, 0, 1, 2'd2, 0, 4'b1111, 0, 0, 1, 0, 2'd1, 0));
        end
        cyc(mk("lock_beat0", 1, 2'd1, 1, 1, 2'd2, 0, 4'b1111, 0, 0, 1, 0, 2'd1, 0));
        cyc(mk("lock_mid", 1, 2'd1, 1, 1, 2'd2, 0, 4'b1111, 0, 0, 1, 0, 2'd1, 0));
        #1;
        rst = 1'b0;
        #1;
        check("async_reset", outs(), 7'd0);
        repeat (2) @(negedge clk);
        drive(mk("rst", 0, 2'd0, 0, 1, 2'd2, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 0));
        rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc(mk("post_reset", 1, 2'd1, 0, 1, 2'd2, 0, 4'b1111, 0, 0,
                   i != 8, i == 8, (i == 8) ? 2'd2 : 2'd1, 0));
        end

        // Fence raised mid-lock: final load beat still issues, then loads stop.
        cyc(mk("fl_beat0", 1, 2'd1, 1, 0, 2'd0, 0, 4'b1111, 0, 1, 1, 0, 2'd1, 0));
        cyc(mk("fl_beat1", 1, 2'd1, 0, 0, 2'd0, 0, 4'b1111, 1, 1, 1, 0, 2'd1, 0));
        @(negedge clk);
        drive(mk("fl", 1, 2'd1, 0, 0, 2'd0, 0, 4'b1111, 1, 1, 0, 0, 2'd0, 0));
        #1;
        o = outs();
        check("fl_no_load", {4'd0, o[6:4]}, 7'd0);
        cyc(mk("fl_ack", 1, 2'd1, 0, 0, 2'd0, 0, 4'b1111, 1, 1, 0, 0, 2'd0, 1));
        cyc(mk("fl_exit", 1, 2'd1, 0, 0, 2'd0, 0, 4'b1111, 0, 1, 0, 0, 2'd0, 1));
        cyc(mk("fl_resume", 1, 2'd1, 0, 0, 2'd0, 0, 4'b1111, 0, 1, 1, 0, 2'd1, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
